// File: rtl/divide.sv
// rtl/divide.sv - sequential restoring unsigned divider, one quotient bit per clock
//
// Computes D = A / B and R = A % B for unsigned WIDTH-bit operands.
// Divide-by-zero yields D = all ones, R = A, err = 1. This matches RISC-V DIVU/REMU.
//
// Ports:
//   clk    in   rising-edge clock
//   reset  in   synchronous active-high reset; aborts any operation in progress
//   start  in   level request; sampled in IDLE, must drop to leave DONE
//   A      in   dividend (WIDTH)
//   B      in   divisor  (WIDTH)
//   D      out  quotient, registered, updates only on entry to DONE
//   R      out  remainder, registered, updates only on entry to DONE
//   ok     out  result valid; high while in DONE
//   err    out  divide-by-zero flag, meaningful while ok = 1
module divide #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] R,
    output logic             ok,
    output logic             err
);

    localparam int             CW   = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] q_q, q_d;       // dividend shifting out, quotient shifting in
    logic [WIDTH-1:0] rem_q, rem_d;   // partial remainder
    logic [WIDTH-1:0] div_q, div_d;   // latched divisor
    logic [WIDTH-1:0] d_q, d_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic             ok_q, ok_d;
    logic             err_q, err_d;

    // One restoring step. The shifted remainder keeps its top bit, so a
    // divisor above 2^(WIDTH-1) still compares correctly.
    logic [WIDTH:0]   rem_shift;
    logic             ge;
    logic [WIDTH-1:0] rem_diff;
    logic [WIDTH-1:0] rem_step;
    logic [WIDTH-1:0] q_step;

    always_comb begin
        rem_shift = {rem_q, q_q[WIDTH-1]};
        ge        = (rem_shift >= {1'b0, div_q});
        // When ge holds, the true difference is below div_q, so WIDTH bits suffice.
        rem_diff  = rem_shift[WIDTH-1:0] - div_q;
        rem_step  = ge ? rem_diff : rem_shift[WIDTH-1:0];
        q_step    = {q_q[WIDTH-2:0], ge};
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        rem_d   = rem_q;
        div_d   = div_q;
        d_d     = d_q;
        r_d     = r_q;
        ok_d    = ok_q;
        err_d   = err_q;

        case (state_q)
            S_IDLE: begin
                ok_d  = 1'b0;
                err_d = 1'b0;
                if (start) begin
                    if (B == '0) begin
                        d_d     = '1;
                        r_d     = A;
                        ok_d    = 1'b1;
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        q_d     = A;
                        div_d   = B;
                        rem_d   = '0;
                        cnt_d   = '0;
                        state_d = S_BUSY;
                    end
                end
            end
            S_BUSY: begin
                q_d   = q_step;
                rem_d = rem_step;
                cnt_d = cnt_q + CW'(1);
                // The final step publishes its own result on the same edge.
                if (cnt_q == LAST) begin
                    d_d     = q_step;
                    r_d     = rem_step;
                    ok_d    = 1'b1;
                    err_d   = 1'b0;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (!start) begin
                    ok_d    = 1'b0;
                    err_d   = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                ok_d    = 1'b0;
                err_d   = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            q_q     <= '0;
            rem_q   <= '0;
            div_q   <= '0;
            d_q     <= '0;
            r_q     <= '0;
            ok_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            rem_q   <= rem_d;
            div_q   <= div_d;
            d_q     <= d_d;
            r_q     <= r_d;
            ok_q    <= ok_d;
            err_q   <= err_d;
        end
    end

    assign D   = d_q;
    assign R   = r_q;
    assign ok  = ok_q;
    assign err = err_q;

endmodule

// File: tb/tb_divide.sv
// tb/tb_divide.sv - testbench for divide
module tb_divide;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [W-1:0] A, B;
    logic [W-1:0] D, R;
    logic         ok, err;

    int total = 0;
    int bad   = 0;

    divide #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .A     (A),
        .B     (B),
        .D     (D),
        .R     (R),
        .ok    (ok),
        .err   (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain arithmetic with the RISC-V divide-by-zero convention.
    function automatic logic [W-1:0] ref_q(input logic [W-1:0] a, input logic [W-1:0] b);
        return (b == 0) ? {W{1'b1}} : a / b;
    endfunction

    function automatic logic [W-1:0] ref_r(input logic [W-1:0] a, input logic [W-1:0] b);
        return (b == 0) ? a : a % b;
    endfunction

    // Drive one division and check latency, results, stability and release.
    // scramble: alter A/B mid-operation to show operands were latched.
    task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b,
                           input bit scramble, input int hold);
        logic [W-1:0] prev_d, prev_r, eq, er;
        int n;
        eq = ref_q(a, b);
        er = ref_r(a, b);
        prev_d = D;
        prev_r = R;
        @(negedge clk);
        A = a; B = b; start = 1'b1;
        n = 0;
        do begin
            @(posedge clk);
            @(negedge clk);
            n++;
            if (n == 10 && b != 0) begin
                chk("busy_hold_d", D, prev_d);
                chk("busy_ok_low", ok, 1'b0);
            end
            if (scramble && n == 5) begin
                A = $urandom; B = $urandom;
            end
        end while (!ok && n < 40);
        chk("latency", n, (b == 0) ? 1 : W + 1);
        chk("quot", D, eq);
        chk("rem", R, er);
        chk("err", err, (b == 0));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            @(negedge clk);
        end
        if (hold > 0) begin
            chk("hold_ok", ok, 1'b1);
            chk("hold_quot", D, eq);
            chk("hold_rem", R, er);
        end
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("release_ok", ok, 1'b0);
        chk("release_err", err, 1'b0);
        chk("release_quot", D, eq);
        chk("release_rem", R, er);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; A = '0; B = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_d", D, 0);
        chk("rst_r", R, 0);
        chk("rst_ok", ok, 1'b0);
        chk("rst_err", err, 1'b0);
        reset = 1'b0;

        run_div(32'd1023, 32'd50, 1'b0, 8);
        run_div(32'd5, 32'd9, 1'b0, 0);
        run_div(32'hFFFFFFFF, 32'd1, 1'b0, 0);
        run_div(32'hFFFFFFFF, 32'h80000001, 1'b0, 0);
        run_div(32'd7, 32'd0, 1'b0, 3);
        run_div(32'd0, 32'd12345, 1'b0, 0);

        // Reset during BUSY aborts the operation.
        @(negedge clk);
        A = 32'd100; B = 32'd7; start = 1'b1;
        repeat (11) @(posedge clk);
        @(negedge clk);
        reset = 1'b1; start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("abort_d", D, 0);
        chk("abort_r", R, 0);
        chk("abort_ok", ok, 1'b0);
        chk("abort_err", err, 1'b0);
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("idle_ok", ok, 1'b0);
        run_div(32'd100, 32'd7, 1'b0, 0);

        run_div(32'hDEADBEEF, 32'h00001234, 1'b1, 0);

        for (int k = 0; k < 16; k++) begin
            logic [W-1:0] ra, rb;
            ra = $urandom;
            case (k % 4)
                0: rb = $urandom_range(1, 255);
                1: rb = $urandom;
                2: rb = 32'h80000000 | $urandom;
                default: rb = (k == 7) ? 32'd0 : ($urandom >> $urandom_range(0, 31));
            endcase
            run_div(ra, rb, (k % 3) == 0, k % 2);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
